// File: rtl/sg_sensor_pkg.sv
// Shared definitions for the trig/echo ultrasonic sensor interface.
// Holds the sensor state encoding and the default microsecond timing so that
// the initiator (alg_box) and the responder emulator (echo_emu) agree.
package sg_sensor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        SETUP,
        ECHO,
        HOLDOFF
    } sensor_state_t;

    localparam int unsigned TRIG_MIN_US_DEF = 10;
    localparam int unsigned SETUP_US_DEF    = 200;
    localparam int unsigned TIMEOUT_US_DEF  = 38000;
    localparam int unsigned HOLDOFF_US_DEF  = 60000;

    // "No target" (0) and anything beyond the timeout both report the timeout.
    function automatic logic [15:0] echo_width(input logic [15:0] cfg,
                                               input logic [15:0] timeout);
        if (cfg == '0 || cfg > timeout)
            return timeout;
        else
            return cfg;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears both flops
//   d    - asynchronous input
//   q    - synchronized output, two clk cycles behind d
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/echo_emu.sv
// Ultrasonic range-sensor emulator (responder side of trig/echo).
// Qualifies a trigger pulse width, waits the setup time, then drives an echo
// pulse whose width in microseconds comes from cfg_echo_us, followed by a
// hold-off during which triggers are ignored. Timing is paced by pluse_us.
// Ports:
//   clk_sys     - system clock
//   rst         - synchronous active-high reset
//   pluse_us    - one-cycle strobe, once per microsecond
//   trig        - trigger from the initiator (asynchronous)
//   cfg_echo_us - echo width in us, 0 = no target
//   echo        - registered echo pulse
//   busy        - high whenever not idle
//   done        - one-cycle pulse as echo falls
//   err_short   - one-cycle pulse when a trigger is rejected as too short
module echo_emu
    import sg_sensor_pkg::*;
#(
    parameter int unsigned TRIG_MIN_US = TRIG_MIN_US_DEF,
    parameter int unsigned SETUP_US    = SETUP_US_DEF,
    parameter int unsigned TIMEOUT_US  = TIMEOUT_US_DEF,
    parameter int unsigned HOLDOFF_US  = HOLDOFF_US_DEF
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        pluse_us,
    input  logic        trig,
    input  logic [15:0] cfg_echo_us,
    output logic        echo,
    output logic        busy,
    output logic        done,
    output logic        err_short
);

    localparam logic [15:0] TRIG_MIN     = 16'(TRIG_MIN_US);
    localparam logic [15:0] SETUP_LAST   = 16'(SETUP_US - 1);
    localparam logic [15:0] TIMEOUT      = 16'(TIMEOUT_US);
    localparam logic [15:0] HOLDOFF_LAST = 16'(HOLDOFF_US - 1);

    sensor_state_t state;
    sensor_state_t state_nxt;

    logic        trig_s;
    logic        trig_q;
    logic [2:0]  prime;
    logic        trig_rise;
    logic        trig_fall;
    logic [15:0] cnt;
    logic [15:0] width_r;
    logic        latch_width;
    logic        short_rej;

    sync2 u_trig_sync (
        .clk (clk_sys),
        .rst (rst),
        .d   (trig),
        .q   (trig_s)
    );

    // The synchronizer and edge flop all reset to 0, so a trigger held high
    // through reset would otherwise look like a fresh rising edge once it
    // propagates. Rising edges are masked until the pipeline holds real data.
    assign trig_rise = trig_s & ~trig_q & prime[2];
    assign trig_fall = ~trig_s & trig_q;

    always_ff @(posedge clk_sys) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        latch_width = 1'b0;
        short_rej   = 1'b0;
        case (state)
            IDLE: begin
                if (trig_rise)
                    state_nxt = TRIG_HI;
            end
            TRIG_HI: begin
                if (trig_fall) begin
                    if (cnt >= TRIG_MIN) begin
                        latch_width = 1'b1;
                        state_nxt   = SETUP;
                    end else begin
                        short_rej   = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            SETUP: begin
                if (pluse_us && cnt == SETUP_LAST)
                    state_nxt = ECHO;
            end
            ECHO: begin
                if (pluse_us && cnt == width_r - 16'd1)
                    state_nxt = HOLDOFF;
            end
            HOLDOFF: begin
                if (pluse_us && cnt == HOLDOFF_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from state_nxt so each flop lines up with the state
    // register: echo mirrors ECHO, and done coincides with echo falling.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            trig_q    <= 1'b0;
            prime     <= '0;
            cnt       <= '0;
            width_r   <= '0;
            echo      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_short <= 1'b0;
        end else begin
            trig_q <= trig_s;
            prime  <= {prime[1:0], 1'b1};

            if (state_nxt != state || state == IDLE)
                cnt <= '0;
            else if (pluse_us && cnt != '1)
                cnt <= cnt + 16'd1;

            if (latch_width)
                width_r <= echo_width(cfg_echo_us, TIMEOUT);

            echo      <= (state_nxt == ECHO);
            busy      <= (state_nxt != IDLE);
            done      <= (state == ECHO) && (state_nxt == HOLDOFF);
            err_short <= short_rej;
        end
    end

endmodule

// File: tb/tb_echo_emu.sv
// Directed self-checking bench for echo_emu with scaled-down timing:
// pluse_us every 4 clocks, TRIG_MIN 10 us, SETUP 20 us, TIMEOUT 1000 us,
// HOLDOFF 600 us.
module tb_echo_emu;

    localparam int P    = 4;
    localparam int SET  = 20;
    localparam int TOUT = 1000;
    localparam int HOLD = 600;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        pluse_us = 1'b0;
    logic        trig = 1'b0;
    logic [15:0] cfg_echo_us = '0;
    logic        echo, busy, done, err_short;

    int checks = 0;
    int errors = 0;

    int  rises = 0, dones = 0, errs = 0, done_bad = 0;
    int  width = 0;
    time t_rise = 0, t_fall = 0, t_busy_fall = 0, t_tfall = 0;
    logic echo_prev = 1'b0, busy_prev = 1'b0;

    int r0, d0, e0;

    echo_emu #(
        .TRIG_MIN_US (10),
        .SETUP_US    (SET),
        .TIMEOUT_US  (TOUT),
        .HOLDOFF_US  (HOLD)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .pluse_us    (pluse_us),
        .trig        (trig),
        .cfg_echo_us (cfg_echo_us),
        .echo        (echo),
        .busy        (busy),
        .done        (done),
        .err_short   (err_short)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        forever begin
            repeat (P - 1) @(posedge clk_sys);
            #1 pluse_us = 1'b1;
            @(posedge clk_sys);
            #1 pluse_us = 1'b0;
        end
    end

    // Event monitor: timestamps and counts of output activity.
    always @(negedge clk_sys) begin
        if (echo === 1'b1 && echo_prev !== 1'b1) begin
            rises++;
            t_rise = $time;
        end
        if (echo === 1'b0 && echo_prev === 1'b1) begin
            t_fall = $time;
            width  = int'(($time - t_rise) / 10);
        end
        if (done === 1'b1) begin
            dones++;
            if (!(echo_prev === 1'b1 && echo === 1'b0))
                done_bad++;
        end
        if (err_short === 1'b1)
            errs++;
        if (busy === 1'b0 && busy_prev === 1'b1)
            t_busy_fall = $time;
        echo_prev = echo;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic trig_pulse(input int us);
        @(negedge clk_sys);
        trig = 1'b1;
        repeat (us * P) @(negedge clk_sys);
        trig = 1'b0;
        t_tfall = $time;
    endtask

    task automatic wait_echo(input logic lvl, input int lim, input string tag);
        int n = 0;
        while (echo !== lvl && n < lim) begin
            @(negedge clk_sys);
            n++;
        end
        #1;
        chk(tag, 32'(echo), 32'(lvl));
    endtask

    task automatic wait_idle(input int lim, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < lim) begin
            @(negedge clk_sys);
            n++;
        end
        #1;
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset with trigger held high: nothing may happen after release.
        trig = 1'b1;
        repeat (5) @(negedge clk_sys);
        #1;
        chk("rst_echo", 32'(echo), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_short), 0);
        @(negedge clk_sys);
        rst = 1'b0;
        repeat (30) @(negedge clk_sys);
        #1;
        chk("held_trig_busy", 32'(busy), 0);
        trig = 1'b0;
        repeat (10) @(negedge clk_sys);
        #1;
        chk("held_trig_release_busy", 32'(busy), 0);
        chk("held_trig_no_err", errs, 0);

        // Nominal 580 us echo from a 12 us trigger.
        cfg_echo_us = 16'd580;
        r0 = rises; d0 = dones;
        trig_pulse(12);
        wait_echo(1'b1, 200, "nom_echo_rise");
        chk_rng("nom_setup_delay", int'((t_rise - t_tfall) / 10), SET * P, (SET + 1) * P + 3);
        chk("nom_busy_in_echo", 32'(busy), 1);
        wait_echo(1'b0, 3000, "nom_echo_fall");
        chk_rng("nom_width", width, 580 * P - 1, 580 * P + 1);
        wait_idle(3000, "nom_idle");
        chk_rng("nom_holdoff", int'((t_busy_fall - t_fall) / 10), HOLD * P - 1, HOLD * P + 1);
        chk("nom_echo_count", rises - r0, 1);
        chk("nom_done_count", dones - d0, 1);

        // Short triggers: 5 us and 9 us are both under the 10 us minimum.
        e0 = errs; r0 = rises;
        trig_pulse(5);
        repeat (4) @(negedge clk_sys);
        #1;
        chk("short5_busy", 32'(busy), 0);
        chk("short5_err_count", errs - e0, 1);
        trig_pulse(9);
        repeat (40) @(negedge clk_sys);
        #1;
        chk("short9_err_count", errs - e0, 2);
        chk("short_no_echo", rises - r0, 0);

        // No target, then an over-range width: both clamp to the timeout.
        cfg_echo_us = 16'd0;
        trig_pulse(11);
        wait_echo(1'b1, 200, "zero_echo_rise");
        wait_echo(1'b0, 5000, "zero_echo_fall");
        chk_rng("zero_width", width, TOUT * P - 1, TOUT * P + 1);
        wait_idle(3000, "zero_idle");
        cfg_echo_us = 16'd50000;
        trig_pulse(11);
        wait_echo(1'b1, 200, "big_echo_rise");
        wait_echo(1'b0, 5000, "big_echo_fall");
        chk_rng("big_width", width, TOUT * P - 1, TOUT * P + 1);
        wait_idle(3000, "big_idle");

        // Config change in SETUP and triggers during ECHO and HOLDOFF are ignored.
        cfg_echo_us = 16'd580;
        r0 = rises; d0 = dones; e0 = errs;
        trig_pulse(12);
        repeat (20) @(negedge clk_sys);
        cfg_echo_us = 16'd100;
        wait_echo(1'b1, 200, "ign_echo_rise");
        repeat (200 * P) @(negedge clk_sys);
        trig_pulse(12);
        wait_echo(1'b0, 3000, "ign_echo_fall");
        chk_rng("ign_width_kept", width, 580 * P - 1, 580 * P + 1);
        repeat (100 * P) @(negedge clk_sys);
        trig_pulse(12);
        wait_idle(3000, "ign_idle");
        chk("ign_echo_count", rises - r0, 1);
        chk("ign_done_count", dones - d0, 1);
        chk("ign_no_err", errs - e0, 0);

        // Next trigger after hold-off is accepted with the new width.
        trig_pulse(12);
        wait_echo(1'b1, 200, "next_echo_rise");
        wait_echo(1'b0, 1000, "next_echo_fall");
        chk_rng("next_width", width, 100 * P - 1, 100 * P + 1);
        chk("next_echo_count", rises - r0, 2);

        // Trigger already high when hold-off ends must not start a measurement.
        repeat (500 * P) @(negedge clk_sys);
        trig = 1'b1;
        wait_idle(1000, "late_idle");
        repeat (100) @(negedge clk_sys);
        #1;
        chk("late_trig_busy", 32'(busy), 0);
        trig = 1'b0;
        repeat (20) @(negedge clk_sys);
        #1;
        chk("late_trig_no_echo", rises - r0, 2);
        chk("late_trig_no_err", errs - e0, 0);

        // Reset 300 us into a 580 us echo.
        cfg_echo_us = 16'd580;
        trig_pulse(12);
        wait_echo(1'b1, 200, "rstmid_echo_rise");
        repeat (300 * P) @(negedge clk_sys);
        d0 = dones;
        rst = 1'b1;
        @(negedge clk_sys);
        #1;
        chk("rstmid_echo", 32'(echo), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk_sys);
        #1;
        chk("rstmid_stays_idle", 32'(busy), 0);
        chk("rstmid_no_done", dones - d0, 0);
        chk("done_alignment", done_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
